// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions raw, bouncing board switches for the CPU.
// Each bit is passed through a two-flop synchronizer. A per-bit stability
// counter then confirms the level before the clean output vector updates.
// A one-cycle change pulse is produced per bit, plus a combined any_change flag.
// Optional build macro SWITCH_LATCH_EN adds sticky change flags
// (changed_latched) that are cleared by clear_latch. Without the macro,
// changed_latched is tied to 0 and no latch flops are built.
// Reset is asynchronous and active low (reset==0 clears all state).

module switch_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] changed,
  output logic             any_change,
  input  logic             clear_latch,
  output logic [WIDTH-1:0] changed_latched
);

  // Terminal count: once a differing bit has been seen this many times
  // already, the next differing sample commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] update;

  // Two-flop synchronizer per bit, nothing between the flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit compare against the stable level and detect a completed count.
  always_comb begin
    differ = '0;
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      differ[i] = sync2[i] ^ switches[i];
      update[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Stability counters: count while differing, restart on agreement or commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || update[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered outputs: commit new level, one-cycle pulses, combined flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      switches   <= '0;
      changed    <= '0;
      any_change <= 1'b0;
    end else begin
      switches   <= switches ^ update;
      changed    <= update;
      any_change <= |update;
    end
  end

`ifdef SWITCH_LATCH_EN
  // Sticky flags: set on a commit, a clear drops only bits not committing now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_latched <= '0;
    end else if (clear_latch) begin
      changed_latched <= update;
    end else begin
      changed_latched <= changed_latched | update;
    end
  end
`else
  // Feature not built: flags stay low and clear_latch is intentionally unused.
  logic unused_clear_latch;
  assign unused_clear_latch = clear_latch;
  assign changed_latched    = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: randomized and directed stimulus for switch_debouncer
// (WIDTH=10, DEBOUNCE_CYCLES=4). A reference model inside the bench computes
// the outputs from the behavioural rules. A bit commits when the last
// DEBOUNCE_CYCLES synchronized samples all differ from the stable level and
// no commit has happened within that window. Define SWITCH_LATCH_EN for both
// the design and the bench to cover the sticky flags.

module tb_switch_debouncer;

  localparam int W = 10;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] switches_raw;
  logic [W-1:0] switches;
  logic [W-1:0] changed;
  logic         any_change;
  logic         clear_latch;
  logic [W-1:0] changed_latched;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches_raw(switches_raw),
    .switches(switches),
    .changed(changed),
    .any_change(any_change),
    .clear_latch(clear_latch),
    .changed_latched(changed_latched)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_s1, m_s2, m_sw, m_chg, m_lat;
  logic         m_any;
  logic [W-1:0] hist[$];   // synchronized value seen at each evaluation since reset
  int           last_upd[W];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_sw = '0; m_chg = '0; m_lat = '0; m_any = 1'b0;
    hist.delete();
    for (int i = 0; i < W; i++) last_upd[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw, input logic clr);
    logic [W-1:0] upd;
    int           n;
    bit           all_diff;
    hist.push_back(m_s2);
    n   = hist.size();
    upd = '0;
    for (int i = 0; i < W; i++) begin
      if (n - last_upd[i] >= D) begin
        all_diff = 1'b1;
        for (int k = n - D; k < n; k++) begin
          if (hist[k][i] == m_sw[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          upd[i]      = 1'b1;
          last_upd[i] = n;
        end
      end
    end
    m_sw  = m_sw ^ upd;
    m_chg = upd;
    m_any = |upd;
`ifdef SWITCH_LATCH_EN
    m_lat = clr ? upd : (m_lat | upd);
`else
    m_lat = '0;
    if (clr) m_lat = '0;
`endif
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs, advance one rising edge, then compare everything.
  task automatic tick(input logic [W-1:0] raw, input logic clr);
    switches_raw = raw;
    clear_latch  = clr;
    @(posedge clk);
    model_edge(raw, clr);
    #1;
    check("switches", switches, m_sw);
    check("changed", changed, m_chg);
    check("any_change", W'(any_change), W'(m_any));
    check("changed_latched", changed_latched, m_lat);
  endtask

  // Assert reset mid-cycle, confirm outputs clear without a clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_switches", switches, '0);
    check("rst_changed", changed, '0);
    check("rst_any", W'(any_change), '0);
    check("rst_latched", changed_latched, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] raw;
    logic [W-1:0] seen;
    int           pulses;

    reset        = 1'b0;
    switches_raw = '0;
    clear_latch  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_switches", switches, '0);
    check("init_any", W'(any_change), '0);
    reset = 1'b1;

    // Quiet input after reset.
    repeat (20) tick('0, 1'b0);

    // Clean step on bit 0: commit on the sixth edge.
    for (int k = 1; k <= 8; k++) begin
      tick(10'h001, 1'b0);
      if (k == 5) check("step_before", switches, 10'h000);
      if (k == 6) begin
        check("step_sw", switches, 10'h001);
        check("step_chg", changed, 10'h001);
        check("step_any", W'(any_change), 10'h001);
      end
      if (k == 7) check("step_chg_gone", changed, 10'h000);
    end

    // Three-cycle glitch on bit 9 is rejected.
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      tick(10'h201, 1'b0);
      seen |= changed;
    end
    for (int k = 0; k < 10; k++) begin
      tick(10'h001, 1'b0);
      seen |= changed;
    end
    check("glitch_sw", switches, 10'h001);
    check("glitch_chg", seen, 10'h000);

    // Bounce bit 3, then hold high: one commit six edges after the hold.
    tick(10'h009, 1'b0);
    tick(10'h001, 1'b0);
    tick(10'h009, 1'b0);
    tick(10'h001, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(10'h009, 1'b0);
      if (changed[3]) pulses++;
      if (k == 5) check("bounce_before", switches, 10'h001);
      if (k == 6) check("bounce_sw", switches, 10'h009);
    end
    check("bounce_pulses", W'(pulses), W'(1));

    // Step to all ones, reset mid-count, then recount from scratch.
    for (int k = 0; k < 4; k++) tick(10'h3FF, 1'b0);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(10'h3FF, 1'b0);
      if (k == 5) check("rstmid_before", switches, 10'h000);
      if (k == 6) check("rstmid_sw", switches, 10'h3FF);
    end

`ifdef SWITCH_LATCH_EN
    // Sticky flag on bit 5, then clear in the same cycle bit 6 commits.
    do_reset();
    for (int k = 0; k < 6; k++) tick(10'h020, 1'b0);
    check("latch_set", changed_latched, 10'h020);
    for (int k = 0; k < 10; k++) tick(10'h020, 1'b0);
    check("latch_hold", changed_latched, 10'h020);
    for (int k = 1; k <= 6; k++) tick(10'h060, (k == 6));
    check("latch_clr_set", changed_latched, 10'h040);
    tick(10'h060, 1'b0);
`endif

    // Randomized phase: sporadic bit flips, clears and resets.
    raw = switches_raw;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
      end
      tick(raw, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
